// File: rtl/qdr_bank_arbiter.sv
// Round-robin arbiter sharing one QDR bank command port among NUM_REQ requesters.
// Reads are tracked in an in-order tag FIFO so returned data is steered back.
module qdr_bank_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 144,
   parameter int TAG_DEPTH  = 16
) (
   input  logic                             axi_aclk,
   input  logic                             axi_reset,
   input  logic                             cal_done,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             mem_cmd_valid,
   input  logic                             mem_cmd_ready,
   output logic                             mem_cmd_wr,
   output logic [ADDR_WIDTH-1:0]            mem_cmd_addr,
   output logic [DATA_WIDTH-1:0]            mem_cmd_wdata,
   input  logic                             mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]            mem_rd_data,
   output logic [NUM_REQ-1:0]               rd_valid,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic [$clog2(TAG_DEPTH):0]       rd_outstanding,
   output logic                             err_underflow
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TAG_DEPTH);
   localparam int OW = TW + 1;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gidx;
   logic [PW-1:0]      idx;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic               found;
   logic               slot_free;
   logic               pop;
   logic               push;
   logic               tag_ok;

   logic [PW-1:0]      tag_mem [TAG_DEPTH];
   logic [TW-1:0]      wr_ptr;
   logic [TW-1:0]      rd_ptr;

   assign slot_free = !mem_cmd_valid | mem_cmd_ready;
   assign pop       = mem_rd_valid & (rd_outstanding != '0);
   // A same-cycle pop frees a tag for this cycle's grant.
   assign tag_ok    = (rd_outstanding != OW'(TAG_DEPTH)) | pop;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] & cal_done & slot_free & !axi_reset
                 & (req_wr[i] | tag_ok);
      end
   end

   always_comb begin
      gnt   = '0;
      gidx  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (!found && elig[idx]) begin
            found    = 1'b1;
            gidx     = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

   assign req_ready = gnt;
   assign push      = found & !req_wr[gidx];

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         ptr           <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_wr    <= 1'b0;
         mem_cmd_addr  <= '0;
         mem_cmd_wdata <= '0;
      end else if (found) begin
         ptr           <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
         mem_cmd_valid <= 1'b1;
         mem_cmd_wr    <= req_wr[gidx];
         mem_cmd_addr  <= req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
         mem_cmd_wdata <= req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      end else if (slot_free) begin
         mem_cmd_valid <= 1'b0;
      end
   end

   // Tag storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge axi_aclk) begin
      if (push) tag_mem[wr_ptr] <= gidx;
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         rd_outstanding <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
            2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
            default: rd_outstanding <= rd_outstanding;
         endcase
      end
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         rd_valid      <= '0;
         rd_data       <= '0;
         err_underflow <= 1'b0;
      end else begin
         rd_valid <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
         if (pop) rd_data <= mem_rd_data;
         if (mem_rd_valid && rd_outstanding == '0) err_underflow <= 1'b1;
      end
   end

endmodule

// File: doc/qdr_bank_arbiter.md
# qdr_bank_arbiter

Round-robin arbiter that shares one QDR-II SRAM bank controller command port among `NUM_REQ` requesters inside the hravframework core. It registers the granted command toward the bank controller and tracks outstanding reads in an in-order tag FIFO. Returned read data is steered back to the requester that issued the read. One instance sits in front of each of the three QDR banks (0/1/2).

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 19: word address width, matching the `qdr_sa` width.
- `DATA_WIDTH`, default 144: one burst-of-4 of 36-bit QDR words.
- `TAG_DEPTH`, default 16: maximum outstanding reads; must be a power of 2.

Ports:
- `axi_aclk` in 1: sole clock. Everything is rising-edge.
- `axi_reset` in 1: asynchronous, active-high reset.
- `cal_done` in 1: the bank controller is calibrated. No grant is issued while it is low.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_wr` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i is at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `req_ready` out NUM_REQ: one-hot grant. The command is accepted when `req_valid[i] & req_ready[i]`.
- `mem_cmd_valid` out 1, `mem_cmd_ready` in 1: command handshake to the bank controller.
- `mem_cmd_wr` out 1, `mem_cmd_addr` out ADDR_WIDTH, `mem_cmd_wdata` out DATA_WIDTH: registered command fields.
- `mem_rd_valid` in 1, `mem_rd_data` in DATA_WIDTH: in-order read return from the controller.
- `rd_valid` out NUM_REQ: one-hot read return strobe.
- `rd_data` out DATA_WIDTH: shared return data. Qualified by `rd_valid`.
- `rd_outstanding` out log2(TAG_DEPTH)+1: current tag FIFO occupancy.
- `err_underflow` out 1: sticky flag. Set when read data arrives with no outstanding read.

## Operation
- **Command slot.** There is a single output register (the slot) holding the `mem_cmd_*` fields.
  - The slot is free when `!mem_cmd_valid | mem_cmd_ready`.
- **Eligibility.** Requester i is eligible when all of the following hold:
  - `req_valid[i]`
  - `cal_done`
  - the slot is free
  - `req_wr[i]`, or `rd_outstanding_next_free`, meaning `rd_outstanding < TAG_DEPTH`.
  - A read-blocked requester is masked, so writes from other requesters still proceed.
- **Arbitration.**
  - Priority pointer `ptr` (log2 NUM_REQ bits, reset 0).
  - The grant goes to the first eligible requester scanning ptr, ptr+1, … modulo NUM_REQ.
  - `req_ready` is combinational from eligibility and `ptr`. At most one bit is set.
  - On acceptance of requester g: `ptr <= (g+1) mod NUM_REQ`. Otherwise `ptr` holds.
- **Acceptance.** On acceptance the slot loads the requester's wr/addr/wdata and `mem_cmd_valid <= 1`.
  - If the slot is free and nothing is accepted, `mem_cmd_valid <= 0`.
  - Fields hold stable while `mem_cmd_valid & !mem_cmd_ready`.
- **Tag FIFO.**
  - An accepted read pushes g, the requester index.
  - `mem_rd_valid` pops the head. The next cycle gives `rd_valid[head] = 1` and `rd_data = mem_rd_data`, registered.
  - Simultaneous push and pop: occupancy is unchanged and both take effect.
  - Pointers wrap modulo TAG_DEPTH.
- **Empty pop.** `mem_rd_valid` while occupancy is 0:
  - the data is dropped and `rd_valid` stays 0;
  - `err_underflow <= 1`, which stays set until reset.
- **Calibration loss.** `cal_done` falling mid-operation blocks new grants only. A command already in the slot and outstanding reads complete normally.
- **Reset.** `axi_reset` asserted at any time:
  - clears the slot, `ptr`, FIFO pointers and occupancy, `rd_valid`, and `err_underflow`;
  - in-flight reads are forgotten. Data returned after reset with an empty FIFO sets `err_underflow`.

## Timing
- **Reset values.** `req_ready` 0 (combinational, since `cal_done` gating applies, but 0 while reset is held), `mem_cmd_valid` 0, `mem_cmd_wr` 0, `mem_cmd_addr` 0, `mem_cmd_wdata` 0, `rd_valid` 0, `rd_data` 0, `rd_outstanding` 0, `err_underflow` 0.
- **Grant to command.** Acceptance in cycle N gives `mem_cmd_valid` = 1 in cycle N+1.
  - Back-to-back acceptance is possible every cycle while `mem_cmd_ready` = 1.
- **Read return.** `mem_rd_valid` in cycle M gives `rd_valid`/`rd_data` in cycle M+1, for exactly one cycle per beat.
- **Occupancy.** `rd_outstanding` updates in the cycle after a push or pop.
  - Eligibility uses the registered value plus the same-cycle pop, so a pop frees a tag for a grant in the same cycle.
- **Stall.** `mem_cmd_ready` = 0 gives `req_ready` = 0 for all requesters and no `ptr` change.

## Test plan
- **Reset and calibration.** Reset, `cal_done` = 0, all `req_valid` = 1 -> `req_ready` = 0 and `mem_cmd_valid` = 0. Raise `cal_done` -> requester 0 is granted first, then 1, 2, 3, 0 on consecutive cycles with `mem_cmd_ready` = 1.
- **Fairness under contention.** Only requesters 1 and 3 valid, `ptr` = 0 -> grants alternate 1,3,1,3. `mem_cmd_addr` follows each grant by one cycle.
- **Read steering.** Reads from requesters 2, 0, 2 are accepted, then three `mem_rd_valid` beats with data 0xA, 0xB, 0xC -> `rd_valid` = 0100, 0001, 0100 with `rd_data` 0xA, 0xB, 0xC, each one cycle after its beat. `rd_outstanding` goes 3 -> 0.
- **Full FIFO.** 16 reads outstanding; requester 0 read-valid, requester 1 write-valid -> only requester 1 is granted. A `mem_rd_valid` in the same cycle as the retry -> requester 0 is granted in that cycle and `rd_outstanding` stays 16.
- **Stall hold.** `mem_cmd_ready` = 0 for 5 cycles with a write to address 0x1234 in the slot -> fields are stable and no grants occur. Release -> the next grant appears in the following cycle.
- **Underflow and mid-operation reset.** `mem_rd_valid` with 0 outstanding -> `err_underflow` = 1 (sticky), `rd_valid` = 0. Assert `axi_reset` with 5 reads outstanding -> all outputs return to 0 immediately (asynchronous) and `rd_outstanding` = 0.
